// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/capture front end for the external ALU.
// Stage D holds the decoded ALU operation; stage R captures the ALU result
// and presents it, with rd and the illegal flag, to writeback.

package alu_issue_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned RIDX_W = 5;

  // ALU operation encodings; AND is 0 so a cleared op register reads as AND.
  typedef enum logic [OPC_W-1:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6
  } alu_opcode_e;

  // Operation bundle presented to the ALU.
  typedef struct packed {
    alu_opcode_e       opcode;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
  } alu_op_t;

endpackage

module alu_issue
  import alu_issue_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     instr,
  input  logic [XLEN-1:0]     rs1_val,
  input  logic [XLEN-1:0]     rs2_val,
  output alu_op_t             alu_op,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic                out_zero,
  output logic [RIDX_W-1:0]   out_rd,
  output logic                out_illegal
);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Instruction fields
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [RIDX_W-1:0] rd;
  logic [XLEN-1:0]   imm_sext;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd       = instr[11:7];
  assign imm_sext = {{(XLEN-12){instr[31]}}, instr[31:20]};

  // Decoded operation for the incoming instruction
  alu_op_t dec_op;
  logic    dec_illegal;

  // Stage D registers
  logic              d_valid_q,   d_valid_d;
  alu_op_t           d_op_q,      d_op_d;
  logic [RIDX_W-1:0] d_rd_q,      d_rd_d;
  logic              d_illegal_q, d_illegal_d;

  // Stage R registers
  logic              r_valid_q,   r_valid_d;
  logic [XLEN-1:0]   r_result_q,  r_result_d;
  logic              r_zero_q,    r_zero_d;
  logic [RIDX_W-1:0] r_rd_q,      r_rd_d;
  logic              r_illegal_q, r_illegal_d;

  // Handshake control
  logic r_load_c;
  logic d_load_c;

  // Decode: map supported R/I arithmetic ops; anything else becomes ADD 0,0 flagged illegal.
  always_comb begin
    dec_op      = '{opcode: ALU_ADD, a: '0, b: '0};
    dec_illegal = 1'b1;
    case (opcode)
      OPC_R: begin
        if (funct7 == F7_BASE && funct3 == F3_ADD) begin
          dec_op      = '{opcode: ALU_ADD, a: rs1_val, b: rs2_val};
          dec_illegal = 1'b0;
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          dec_op      = '{opcode: ALU_SUB, a: rs1_val, b: rs2_val};
          dec_illegal = 1'b0;
        end else if (funct7 == F7_BASE && funct3 == F3_AND) begin
          dec_op      = '{opcode: ALU_AND, a: rs1_val, b: rs2_val};
          dec_illegal = 1'b0;
        end else if (funct7 == F7_BASE && funct3 == F3_OR) begin
          dec_op      = '{opcode: ALU_OR, a: rs1_val, b: rs2_val};
          dec_illegal = 1'b0;
        end
      end
      OPC_I: begin
        case (funct3)
          F3_ADD: begin
            dec_op      = '{opcode: ALU_ADD, a: rs1_val, b: imm_sext};
            dec_illegal = 1'b0;
          end
          F3_AND: begin
            dec_op      = '{opcode: ALU_AND, a: rs1_val, b: imm_sext};
            dec_illegal = 1'b0;
          end
          F3_OR: begin
            dec_op      = '{opcode: ALU_OR, a: rs1_val, b: imm_sext};
            dec_illegal = 1'b0;
          end
          default: begin
            dec_op      = '{opcode: ALU_ADD, a: '0, b: '0};
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_op      = '{opcode: ALU_ADD, a: '0, b: '0};
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Advance control: R drains into writeback, D drains into R, input fills D.
  always_comb begin
    r_load_c = d_valid_q && (!r_valid_q || out_ready);
    in_ready = !d_valid_q || r_load_c;
    d_load_c = in_valid && in_ready;
  end

  // Next-state for both stages; registers hold unless loaded or drained.
  always_comb begin
    d_valid_d   = d_valid_q;
    d_op_d      = d_op_q;
    d_rd_d      = d_rd_q;
    d_illegal_d = d_illegal_q;
    r_valid_d   = r_valid_q;
    r_result_d  = r_result_q;
    r_zero_d    = r_zero_q;
    r_rd_d      = r_rd_q;
    r_illegal_d = r_illegal_q;

    if (r_load_c) begin
      r_valid_d   = 1'b1;
      r_result_d  = alu_result;
      r_zero_d    = alu_zero;
      r_rd_d      = d_rd_q;
      r_illegal_d = d_illegal_q;
    end else if (out_ready) begin
      r_valid_d   = 1'b0;
    end

    if (d_load_c) begin
      d_valid_d   = 1'b1;
      d_op_d      = dec_op;
      d_rd_d      = rd;
      d_illegal_d = dec_illegal;
    end else if (r_load_c) begin
      d_valid_d   = 1'b0;
    end
  end

  // Pipeline registers with asynchronous clear; in-flight work is dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid_q   <= 1'b0;
      d_op_q      <= '0;
      d_rd_q      <= '0;
      d_illegal_q <= 1'b0;
      r_valid_q   <= 1'b0;
      r_result_q  <= '0;
      r_zero_q    <= 1'b0;
      r_rd_q      <= '0;
      r_illegal_q <= 1'b0;
    end else begin
      d_valid_q   <= d_valid_d;
      d_op_q      <= d_op_d;
      d_rd_q      <= d_rd_d;
      d_illegal_q <= d_illegal_d;
      r_valid_q   <= r_valid_d;
      r_result_q  <= r_result_d;
      r_zero_q    <= r_zero_d;
      r_rd_q      <= r_rd_d;
      r_illegal_q <= r_illegal_d;
    end
  end

  assign alu_op      = d_op_q;
  assign out_valid   = r_valid_q;
  assign out_result  = r_result_q;
  assign out_zero    = r_zero_q;
  assign out_rd      = r_rd_q;
  assign out_illegal = r_illegal_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Two-stage issue/capture front end for the `alu` execution unit. It accepts a RISC-V R-type or I-type arithmetic instruction with its source register values over a valid/ready handshake and decodes it into an `alu_op_t` (`opcode`, `a`, `b`) that drives the combinational ALU. It registers the ALU `result`/`zero` and presents them with the destination register index to writeback over a second valid/ready handshake. It sits between register read and writeback. The ALU is instantiated externally and connected through the `alu_op`/`alu_result`/`alu_zero` ports.

## Interface
- No parameters; datapath is fixed at 32 bits.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: instruction/operands valid.
- `in_ready` output 1: block can accept; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `instr` input 32: raw instruction word.
- `rs1_val` input 32: rs1 operand value.
- `rs2_val` input 32: rs2 operand value (ignored for I-type).
- `alu_op` output `alu_op_t`: operation to ALU, driven from the decode register.
- `alu_result` input 32: ALU result (combinational from `alu_op`).
- `alu_zero` input 1: ALU zero flag.
- `out_valid` output 1: writeback record valid.
- `out_ready` input 1: writeback accepts; a transfer occurs when `out_valid && out_ready`.
- `out_result` output 32: captured ALU result.
- `out_zero` output 1: captured zero flag.
- `out_rd` output 5: destination register, `instr[11:7]`.
- `out_illegal` output 1: instruction was not a supported ALU op.

## Operation
- **Decode:** `instr[6:0]`=0110011 (R) or 0010011 (I); `funct3`=`instr[14:12]`, `funct7`=`instr[31:25]`.
- **R-type mappings:**
  - 000/0000000 → ADD.
  - 000/0100000 → SUB.
  - 111/0000000 → AND.
  - 110/0000000 → OR.
  - R-type uses `a=rs1_val`, `b=rs2_val`.
- **I-type mappings:**
  - 000 → ADD (ADDI).
  - 111 → AND (ANDI).
  - 110 → OR (ORI).
  - I-type uses `a=rs1_val`, `b` = sign-extended `instr[31:20]` to 32 bits.
  - `funct7` is ignored for I-type.
- **Illegal instructions:** any other opcode or `funct3`/`funct7` combination is illegal. It is still accepted and flows through with `alu_op` = {ADD, 0, 0}, producing result 0 and zero=1, with `out_illegal`=1.
- **Stage D (decode register):** `d_valid`, `d_op` (`alu_op_t`), `d_rd`, `d_illegal`. `alu_op` = `d_op` at all times.
- **Stage R (output register):** `r_valid`, `r_result`, `r_zero`, `r_rd`, `r_illegal`. These drive the `out_*` ports directly.
- **Advance rules:**
  - `r_load = d_valid && (!r_valid || out_ready)`.
  - `d_load = in_valid && in_ready`.
  - `in_ready = !d_valid || r_load`, which is combinational.
- **Per-edge updates:**
  - If `r_load`, R captures `alu_result`, `alu_zero`, `d_rd` and `d_illegal`, and `r_valid`←1.
  - Else, if `out_ready`, `r_valid`←0.
  - If `d_load`, D captures the decoded input and `d_valid`←1.
  - Else, if `r_load`, `d_valid`←0.
- **Hold behaviour:** R contents hold while `out_valid && !out_ready`. D contents hold while D is stalled, so `alu_op` is stable.
- **Simultaneous events:** D may load a new instruction in the same cycle R loads the old one.
- **rd=x0:** processed normally; `out_rd`=0. Writeback discards it.
- **Reset:** all registers clear to 0 asynchronously. Any in-flight operations are dropped with no output.
  - Output values during reset: `out_valid`=0, `out_result`=0, `out_zero`=0, `out_rd`=0, `out_illegal`=0, `alu_op`={AND enum value 0, 0, 0}.
  - `in_ready`=1 during and after reset.

## Timing
- Latency: an instruction accepted at edge k appears on `out_*` with `out_valid`=1 after edge k+1, and is consumable at edge k+2 at the earliest.
- Throughput: one instruction per cycle with `out_ready` held high.
- Capacity: 2 in flight (D + R). With `out_ready` low, `in_ready` falls once both stages are valid.
- `in_ready` depends combinationally on `out_ready`. `out_*` are pure register outputs.
- The ALU path (D → `alu` → R) is a single-cycle combinational path.

## Test plan
- **Reset/idle:** assert `rst` mid-stream with both stages full → `out_valid`=0 and `in_ready`=1 immediately; the stalled record never appears after reset release.
- **ADD/SUB:**
  - ADD x3,x1,x2 with rs1=5, rs2=7 → `out_result`=12, `out_zero`=0, `out_rd`=3, two cycles after accept.
  - SUB with 9,9 → 0, `out_zero`=1.
- **I-type sign extension:** ADDI x5,x1,-1 (imm 0xFFF) with rs1=1 → result 0, zero=1. ANDI with imm 0x0F0 and rs1=0xFFFF_FFFF → 0x0000_00F0.
- **Illegal:** XOR (funct3=100) and LUI opcode → `out_illegal`=1, result 0, `out_zero`=1, `out_rd`=`instr[11:7]`.
- **Backpressure:** stream 4 ADDs back-to-back with `out_ready` low for 3 cycles → `in_ready` drops after 2 accepts, outputs hold stable. On release, all 4 emerge in order with none lost or duplicated.
- **Full throughput:** 16 random legal ops with `in_valid`/`out_ready` held high → one result per cycle, matching a reference model, in order.
